// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the request legality helpers used at accept time.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

  // Stores only have signed-width encodings; loads add the unsigned variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    ok = 1'b1;
    case (f3)
      F3_H, F3_HU: ok = !off[0];
      F3_W:        ok = (off == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for sub-word accesses: extracts/extends load data and merges
// store data into the old memory word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_val,
  output logic [31:0] o_merged
);

  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;
  logic signed [31:0] w_byte_sx;
  logic signed [31:0] w_half_sx;

  always_comb begin
    w_byte = 8'sd0;
    case (i_off)
      2'd0: w_byte = i_old_word[7:0];
      2'd1: w_byte = i_old_word[15:8];
      2'd2: w_byte = i_old_word[23:16];
      2'd3: w_byte = i_old_word[31:24];
      default: w_byte = 8'sd0;
    endcase
    w_half    = i_off[1] ? i_old_word[31:16] : i_old_word[15:0];
    w_byte_sx = w_byte;
    w_half_sx = w_half;
  end

  always_comb begin
    o_load_val = i_old_word;
    case (i_funct3)
      F3_B:    o_load_val = w_byte_sx;
      F3_H:    o_load_val = w_half_sx;
      F3_BU:   o_load_val = {24'd0, w_byte};
      F3_HU:   o_load_val = {16'd0, w_half};
      default: o_load_val = i_old_word;
    endcase
  end

  always_comb begin
    o_merged = i_old_word;
    case (i_funct3)
      F3_B: begin
        case (i_off)
          2'd0: o_merged[7:0]   = i_wdata[7:0];
          2'd1: o_merged[15:8]  = i_wdata[7:0];
          2'd2: o_merged[23:16] = i_wdata[7:0];
          2'd3: o_merged[31:24] = i_wdata[7:0];
          default: o_merged = i_old_word;
        endcase
      end
      F3_H: begin
        if (i_off[1]) o_merged[31:16] = i_wdata[15:0];
        else          o_merged[15:0]  = i_wdata[15:0];
      end
      F3_W:    o_merged = i_wdata;
      default: o_merged = i_old_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit between the MEM stage and a word-wide data memory.
// IDLE accepts and classifies, ACCESS does the single memory cycle, RESP holds the answer.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 4096,
  parameter bit          CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  r_state;
  logic        r_we_q;
  logic [2:0]  r_funct3_q;
  logic [31:0] r_addr_q;
  logic [31:0] r_wdata_q;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_misalign;
  logic        r_resp_fault;

  logic        w_accept;
  logic        w_misalign;
  logic        w_fault;
  logic [31:0] w_load_val;
  logic [31:0] w_merged;

  assign w_accept   = req_valid && r_req_ready;
  assign w_misalign = !f3_legal(req_we, req_funct3) || !addr_aligned(req_funct3, req_addr[1:0]);
  assign w_fault    = CHECK_RANGE && (req_addr >= 32'(MEM_BYTES));

  lsu_align u_align (
    .i_funct3   (r_funct3_q),
    .i_off      (r_addr_q[1:0]),
    .i_old_word (mem_rdata),
    .i_wdata    (r_wdata_q),
    .o_load_val (w_load_val),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_we_q          <= 1'b0;
      r_funct3_q      <= 3'd0;
      r_addr_q        <= 32'd0;
      r_wdata_q       <= 32'd0;
      r_req_ready     <= 1'b1;
      r_resp_valid    <= 1'b0;
      r_resp_rdata    <= 32'd0;
      r_resp_misalign <= 1'b0;
      r_resp_fault    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we_q          <= req_we;
            r_funct3_q      <= req_funct3;
            r_addr_q        <= req_addr;
            r_wdata_q       <= req_wdata;
            r_req_ready     <= 1'b0;
            r_resp_rdata    <= 32'd0;
            r_resp_misalign <= w_misalign;
            r_resp_fault    <= w_fault;
            // Bad requests never touch memory: skip straight to the response.
            if (w_misalign || w_fault) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!r_we_q) r_resp_rdata <= w_load_val;
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Write gate includes rst so a reset landing mid-ACCESS cancels the write.
  assign mem_we        = (r_state == ACCESS) && r_we_q && !rst;
  assign mem_addr      = {r_addr_q[31:2], 2'b00};
  assign mem_wdata     = w_merged;
  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_misalign = r_resp_misalign;
  assign resp_fault    = r_resp_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed reference memory model, a
// per-cycle output checker and directed load/store vectors.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_fault;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(4096), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign), .resp_fault(resp_fault),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory environment: 1024 words, async read, sync write.
  logic [31:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  // Reference model state: plain byte array.
  logic [7:0] mb [0:4095];

  int checks = 0;
  int failures = 0;

  logic [31:0] e_rdata, e_waddr, e_wdata;
  logic        e_mis, e_fault, e_wr, e_armed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model's expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid && e_armed) begin
        chk("resp_rdata", resp_rdata, e_rdata);
        chk("resp_misalign", 32'(resp_misalign), 32'(e_mis));
        chk("resp_fault", 32'(resp_fault), 32'(e_fault));
        chk("req_ready_in_resp", 32'(req_ready), 32'd0);
      end
      if (mem_we) begin
        chk("mem_we_allowed", 32'(mem_we), 32'(e_wr));
        chk("mem_addr", mem_addr, e_waddr);
        chk("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  function automatic logic [31:0] model_word(input int a);
    return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
  endfunction

  task automatic model_expect(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata);
    int a;
    int sz;
    logic legal;
    sz    = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    e_mis   = !legal || ((addr % sz) != 0);
    e_fault = (addr >= 32'd4096);
    e_rdata = 32'd0;
    e_wr    = 1'b0;
    e_waddr = {addr[31:2], 2'b00};
    e_wdata = 32'd0;
    if (!e_mis && !e_fault) begin
      a = int'(addr[11:0]);
      if (we) begin
        for (int i = 0; i < sz; i++) mb[a+i] = wdata[8*i +: 8];
        e_wr    = 1'b1;
        e_wdata = model_word(a & ~3);
      end else begin
        case (f3)
          3'd0: e_rdata = {{24{mb[a][7]}}, mb[a]};
          3'd1: e_rdata = {{16{mb[a+1][7]}}, mb[a+1], mb[a]};
          3'd2: e_rdata = model_word(a);
          3'd4: e_rdata = {24'd0, mb[a]};
          default: e_rdata = {16'd0, mb[a+1], mb[a]};
        endcase
      end
    end
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold,
                     output logic [31:0] rd, output logic mis, output logic flt);
    bit seen;
    logic [31:0] r0;
    logic m0, f0;
    model_expect(we, f3, addr, wdata);
    e_armed = 1'b1;
    @(negedge clk);
    resp_ready = (hold == 0);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    rd = resp_rdata; mis = resp_misalign; flt = resp_fault;
    if (!seen) begin
      checks++; failures++;
      $display("FAIL resp_timeout actual=no_resp required=resp_valid");
    end else if (hold > 0) begin
      r0 = resp_rdata; m0 = resp_misalign; f0 = resp_fault;
      repeat (hold) begin
        @(negedge clk);
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_rdata", resp_rdata, r0);
        chk("hold_flags", {30'd0, resp_misalign, resp_fault}, {30'd0, m0, f0});
      end
      resp_ready = 1'b1;
    end
    @(negedge clk);
    chk("back_to_idle_valid", 32'(resp_valid), 32'd0);
    chk("back_to_idle_ready", 32'(req_ready), 32'd1);
    e_armed = 1'b0;
    e_wr = 1'b0;
  endtask

  logic [31:0] rd;
  logic mis, flt;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int i = 0; i < 4096; i++) mb[i] = 8'd0;
    e_armed = 1'b0; e_wr = 1'b0; e_mis = 1'b0; e_fault = 1'b0;
    e_rdata = '0; e_waddr = '0; e_wdata = '0;
    rst = 1'b1; resp_ready = 1'b1; req_valid = 1'b0;
    req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_flags", {30'd0, resp_misalign, resp_fault}, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, mis, flt);
    txn(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, mis, flt);
    chk("lit_lw_10", rd, 32'hDEADBEEF);
    chk("lit_lw_10_flags", {30'd0, mis, flt}, 32'd0);

    txn(1'b1, 3'd0, 32'h11, 32'h000000A5, 0, rd, mis, flt);
    txn(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, mis, flt);
    chk("lit_lw_after_sb", rd, 32'hDEADA5EF);
    txn(1'b0, 3'd0, 32'h11, 32'h0, 0, rd, mis, flt);
    chk("lit_lb_11", rd, 32'hFFFFFFA5);
    txn(1'b0, 3'd4, 32'h11, 32'h0, 0, rd, mis, flt);
    chk("lit_lbu_11", rd, 32'h000000A5);
    txn(1'b0, 3'd0, 32'h10, 32'h0, 0, rd, mis, flt);
    chk("lit_lb_10", rd, 32'hFFFFFFEF);

    txn(1'b1, 3'd1, 32'h12, 32'h00007FFF, 0, rd, mis, flt);
    txn(1'b0, 3'd1, 32'h12, 32'h0, 0, rd, mis, flt);
    chk("lit_lh_12", rd, 32'h00007FFF);
    txn(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, mis, flt);
    chk("lit_lw_after_sh", rd, 32'h7FFFA5EF);
    txn(1'b1, 3'd1, 32'h13, 32'h0000FFFF, 0, rd, mis, flt);
    chk("lit_sh_13_mis", 32'(mis), 32'd1);
    txn(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, mis, flt);
    chk("lit_lw_unchanged", rd, 32'h7FFFA5EF);
    txn(1'b1, 3'd1, 32'h16, 32'hFFFF8001, 0, rd, mis, flt);
    txn(1'b0, 3'd1, 32'h16, 32'h0, 0, rd, mis, flt);
    chk("lit_lh_16", rd, 32'hFFFF8001);
    txn(1'b0, 3'd5, 32'h16, 32'h0, 0, rd, mis, flt);
    chk("lit_lhu_16", rd, 32'h00008001);

    txn(1'b0, 3'd2, 32'h1000, 32'h0, 0, rd, mis, flt);
    chk("lit_range_fault", {rd[29:0], mis, flt}, 32'd1);
    txn(1'b0, 3'd3, 32'h10, 32'h0, 0, rd, mis, flt);
    chk("lit_f3_011_mis", {30'd0, mis, flt}, 32'd2);
    txn(1'b1, 3'd4, 32'h10, 32'h11111111, 0, rd, mis, flt);
    chk("lit_store_f3_100_mis", 32'(mis), 32'd1);
    txn(1'b0, 3'd1, 32'h1001, 32'h0, 0, rd, mis, flt);
    chk("lit_both_flags", {30'd0, mis, flt}, 32'd3);

    txn(1'b0, 3'd2, 32'h10, 32'h0, 5, rd, mis, flt);
    chk("lit_backpressure_lw", rd, 32'h7FFFA5EF);

    // Reset during ACCESS of SW 0x20: the write must be suppressed.
    e_wr = 1'b1; e_waddr = 32'h20; e_wdata = 32'h12345678; e_armed = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_in_access_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    e_wr = 1'b0;
    chk("rst_drop_no_resp", 32'(resp_valid), 32'd0);
    chk("rst_drop_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("rst_drop_no_resp_later", 32'(resp_valid), 32'd0);
    txn(1'b0, 3'd2, 32'h20, 32'h0, 0, rd, mis, flt);
    chk("lit_lw_20_after_rst", rd, 32'h00000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
